// File: rtl/user_bram_arbiter_if.sv
// user_bram_arbiter_if: requester (WB, DMA) and BRAM signals of the user BRAM arbiter
interface user_bram_arbiter_if #(parameter int DATA_W = 32, parameter int ADDR_W = 12);
  logic              wb_req, wb_we, wb_ack;
  logic [3:0]        wb_sel;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_wdata, wb_rdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              err, busy;
  logic [3:0]        bram_we;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_di, bram_do;
  modport slave (
    input  wb_req, wb_we, wb_sel, wb_addr, wb_wdata, dma_req, dma_we, dma_addr, dma_wdata, bram_do,
    output wb_ack, wb_rdata, dma_ack, dma_rdata, err, busy, bram_we, bram_en, bram_addr, bram_di
  );
  modport master (
    output wb_req, wb_we, wb_sel, wb_addr, wb_wdata, dma_req, dma_we, dma_addr, dma_wdata, bram_do,
    input  wb_ack, wb_rdata, dma_ack, dma_rdata, err, busy, bram_we, bram_en, bram_addr, bram_di
  );
endinterface

// File: rtl/user_bram_arbiter.sv
// user_bram_arbiter: round-robin WB/DMA arbiter for the single-port user BRAM, fixed latency LAT
module user_bram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 10
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  user_bram_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;
  logic last_grant, gnt, we_q, oob_q;
  logic [3:0] cnt;
  logic [DATA_W-1:0] rdata_q;
  logic pick_dma, p_we, p_oob, go_resp, rd_ok;
  logic [3:0] p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata, rdata_v;
  always_comb begin
    pick_dma = bus.dma_req & (~bus.wb_req | ~last_grant);
    p_we     = pick_dma ? bus.dma_we : bus.wb_we;
    p_sel    = pick_dma ? 4'hF : bus.wb_sel;
    p_addr   = pick_dma ? bus.dma_addr : bus.wb_addr;
    p_wdata  = pick_dma ? bus.dma_wdata : bus.wb_wdata;
    p_oob    = 32'(p_addr) >= DEPTH;
    go_resp  = (state == ACCESS || state == WAIT) && cnt == 4'(LAT - 2);
    rd_ok    = ~we_q & ~oob_q;
    // with LAT=3 the response cycle coincides with the BRAM output cycle
    rdata_v  = (LAT == 3) ? (rd_ok ? bus.bram_do : '0) : rdata_q;
  end
  assign bus.busy      = state != IDLE;
  assign bus.wb_rdata  = bus.wb_ack ? rdata_v : '0;
  assign bus.dma_rdata = bus.dma_ack ? rdata_v : '0;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      gnt           <= 1'b0;
      we_q          <= 1'b0;
      oob_q         <= 1'b0;
      cnt           <= '0;
      rdata_q       <= '0;
      bus.wb_ack    <= 1'b0;
      bus.dma_ack   <= 1'b0;
      bus.err       <= 1'b0;
      bus.bram_en   <= 1'b0;
      bus.bram_we   <= '0;
      bus.bram_addr <= '0;
      bus.bram_di   <= '0;
    end else begin
      bus.bram_en <= 1'b0;
      bus.bram_we <= '0;
      bus.wb_ack  <= 1'b0;
      bus.dma_ack <= 1'b0;
      bus.err     <= 1'b0;
      cnt         <= cnt + 4'd1;
      if (state == IDLE && (bus.wb_req | bus.dma_req)) begin
        state         <= ACCESS;
        gnt           <= pick_dma;
        last_grant    <= pick_dma;
        we_q          <= p_we;
        oob_q         <= p_oob;
        cnt           <= 4'd1;
        bus.bram_en   <= ~p_oob;
        bus.bram_we   <= (p_we & ~p_oob) ? p_sel : 4'h0;
        bus.bram_addr <= p_addr;
        bus.bram_di   <= p_wdata;
      end
      if (state == WAIT && cnt == 4'd2) rdata_q <= rd_ok ? bus.bram_do : '0;
      if (go_resp) begin
        state       <= RESP;
        bus.wb_ack  <= ~gnt;
        bus.dma_ack <= gnt;
        bus.err     <= oob_q;
      end else if (state == ACCESS) state <= WAIT;
      if (state == RESP) state <= IDLE;
    end
endmodule
